encode4_2_seq: RTL

Sequential encoder: the inverse of the team's 2-to-4 decoder. It captures an N-bit request vector W and emits the binary index of every set bit, one index per handshake, in priority order (highest index first). It sits between request-generating logic (one-hot or multi-hot flags) and consumers that take a binary select, e.g. a decoder-driven mux bank.

---
 rtl/encode4_2_seq_if.sv | 28 ++
 rtl/encode4_2_seq.sv | 97 +++++++++
 2 files changed

// File: rtl/encode4_2_seq_if.sv
// Request/index handshake bundle for encode4_2_seq.
// master = request producer / index consumer side, slave = the encoder.
interface encode4_2_seq_if #(
    parameter int N = 4,
    parameter int M = 2
);
    logic [N-1:0] W;
    logic         En;
    logic         Ack;
    logic [M-1:0] Y;
    logic         Valid;
    logic         Ready;
    logic         Done;
    logic         Zero;

    // Handshakes: a load happens on a rising Clock edge where En=1 and
    // Ready=1; an index is consumed on a rising edge where Ack=1 and Valid=1.
    // Y stays stable while Valid=1 and Ack=0.
    modport master (
        output W, En, Ack,
        input  Y, Valid, Ready, Done, Zero
    );

    modport slave (
        input  W, En, Ack,
        output Y, Valid, Ready, Done, Zero
    );
endinterface

// File: rtl/encode4_2_seq.sv
// Sequential priority encoder: emits the index of every set request bit, one per handshake.
// Define ENC_LSB_FIRST_EN to emit lowest index first instead of highest.
module encode4_2_seq #(
    parameter int N = 4,
    parameter int M = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    encode4_2_seq_if.slave   bus,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] p_q, p_d;
    logic [N-1:0] p_clr;
    logic         zero_q, zero_d;
    logic [M-1:0] top_idx;

    // Index of the bit to emit next; the last match in the loop wins.
    always_comb begin
        top_idx = '0;
`ifdef ENC_LSB_FIRST_EN
        for (int i = N - 1; i >= 0; i--) begin
            if (p_q[i]) top_idx = M'(i);
        end
`else
        for (int i = 0; i < N; i++) begin
            if (p_q[i]) top_idx = M'(i);
        end
`endif
    end

    always_comb begin
        p_clr = p_q;
        for (int i = 0; i < N; i++) begin
            if (M'(i) == top_idx) p_clr[i] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        zero_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.En) begin
                    if (bus.W != '0) begin
                        p_d     = bus.W;
                        state_d = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (bus.Ack) begin
                    p_d = p_clr;
                    if (p_clr == '0) state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                p_d     = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            p_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            zero_q  <= zero_d;
        end
    end

    // Moore outputs only: nothing here depends on W, En or Ack.
    assign bus.Valid = (state_q == SCAN);
    assign bus.Ready = (state_q == IDLE);
    assign bus.Done  = (state_q == FIN);
    assign bus.Zero  = zero_q;
    assign bus.Y     = (state_q == SCAN) ? top_idx : '0;
    assign dbg_state = state_q;

endmodule
